// File: rtl/interrupt_controller.sv
// Game Boy interrupt controller: owns IF/IE, edge-detects the five request sources,
// arbitrates by fixed priority and runs the request/acknowledge handshake with the CPU.
module interrupt_controller #(
  parameter logic [15:0] IF_ADDR       = 16'hFF0F,
  parameter logic [15:0] IE_ADDR       = 16'hFFFF,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int unsigned VECTOR_STRIDE = 8
) (
  input  logic        I_CLOCK,
  input  logic        I_RESET_L,
  input  logic [15:0] I_ADDR,
  inout  wire  [7:0]  IO_DATA,
  input  logic        I_RE_L,
  input  logic        I_WE_L,
  input  logic        I_VBLANK_INTERRUPT,
  input  logic        I_LCDC_INTERRUPT,
  input  logic        I_TIMER_INTERRUPT,
  input  logic        I_SERIAL_INTERRUPT,
  input  logic        I_JOYPAD_INTERRUPT,
  input  logic        I_IME,
  input  logic        I_INT_ACK,
  output logic        O_INT_REQ,
  output logic [15:0] O_INT_VECTOR,
  output logic        O_WAKE
);

  localparam int unsigned NUM_SRC = 5;
  localparam int unsigned IDX_W   = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [NUM_SRC-1:0] src;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] if_q;
  logic [NUM_SRC-1:0] if_d;
  logic [NUM_SRC-1:0] pending;
  logic [7:0]         ie_q;
  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic [15:0]        win_vec;
  logic [15:0]        vector_q;
  logic [15:0]        vector_d;
  logic               int_req_q;
  logic               int_req_d;
  logic               ack_clear;
  logic               if_wr;
  logic               ie_wr;
  logic               rd_if;
  logic               rd_ie;

  assign src = {I_JOYPAD_INTERRUPT, I_SERIAL_INTERRUPT, I_TIMER_INTERRUPT,
                I_LCDC_INTERRUPT, I_VBLANK_INTERRUPT};

  assign rise    = src & ~src_q;
  assign pending = if_q & ie_q[NUM_SRC-1:0];
  assign O_WAKE  = |pending;

  // Bus decode; the bus is only ever driven during a matching read.
  assign if_wr   = !I_WE_L && (I_ADDR == IF_ADDR);
  assign ie_wr   = !I_WE_L && (I_ADDR == IE_ADDR);
  assign rd_if   = !I_RE_L && (I_ADDR == IF_ADDR);
  assign rd_ie   = !I_RE_L && (I_ADDR == IE_ADDR);
  assign IO_DATA = rd_if ? {3'b111, if_q} : (rd_ie ? ie_q : 8'hzz);

  // Lowest pending index wins.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) win_idx = IDX_W'(i);
    end
  end

  assign win_vec = VECTOR_BASE + 16'(VECTOR_STRIDE) * 16'(win_idx);

  // Handshake next-state and presented-vector tracking.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vector_d  = vector_q;
    ack_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (I_IME && (|pending)) begin
          state_d  = ST_REQ;
          idx_d    = win_idx;
          vector_d = win_vec;
        end
      end
      ST_REQ: begin
        if (!I_IME || (pending == '0)) begin
          state_d = ST_IDLE;
        end else if (I_INT_ACK) begin
          state_d   = ST_ACK;
          ack_clear = 1'b1;
        end else begin
          idx_d    = win_idx;
          vector_d = win_vec;
        end
      end
      ST_ACK: begin
        if (!I_INT_ACK) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    int_req_d = (state_d == ST_REQ);
  end

  // IF per-bit priority: source edge over ack clear over bus write.
  always_comb begin
    if_d = if_q;
    if (if_wr) if_d = IO_DATA[NUM_SRC-1:0];
    if (ack_clear) if_d[idx_q] = 1'b0;
    if_d = if_d | rise;
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      src_q     <= '0;
      if_q      <= '0;
      ie_q      <= '0;
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      vector_q  <= '0;
      int_req_q <= 1'b0;
    end else begin
      src_q     <= src;
      if_q      <= if_d;
      if (ie_wr) ie_q <= IO_DATA;
      state_q   <= state_d;
      idx_q     <= idx_d;
      vector_q  <= vector_d;
      int_req_q <= int_req_d;
    end
  end

  assign O_INT_REQ    = int_req_q;
  assign O_INT_VECTOR = vector_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
module tb_interrupt_controller;

  logic        I_CLOCK = 1'b0;
  logic        I_RESET_L = 1'b0;
  logic [15:0] I_ADDR = 16'h0000;
  wire  [7:0]  IO_DATA;
  logic        I_RE_L = 1'b1;
  logic        I_WE_L = 1'b1;
  logic        vblank = 1'b0;
  logic        lcdc = 1'b0;
  logic        timer = 1'b0;
  logic        serial = 1'b0;
  logic        joypad = 1'b0;
  logic        ime = 1'b0;
  logic        ack = 1'b0;
  logic        int_req;
  logic [15:0] int_vector;
  logic        wake;

  logic        tb_drv = 1'b0;
  logic [7:0]  tb_data = 8'h00;
  logic [7:0]  rd;
  int          passed = 0;
  int          total = 0;

  assign IO_DATA = tb_drv ? tb_data : 8'hzz;

  interrupt_controller dut (
    .I_CLOCK            (I_CLOCK),
    .I_RESET_L          (I_RESET_L),
    .I_ADDR             (I_ADDR),
    .IO_DATA            (IO_DATA),
    .I_RE_L             (I_RE_L),
    .I_WE_L             (I_WE_L),
    .I_VBLANK_INTERRUPT (vblank),
    .I_LCDC_INTERRUPT   (lcdc),
    .I_TIMER_INTERRUPT  (timer),
    .I_SERIAL_INTERRUPT (serial),
    .I_JOYPAD_INTERRUPT (joypad),
    .I_IME              (ime),
    .I_INT_ACK          (ack),
    .O_INT_REQ          (int_req),
    .O_INT_VECTOR       (int_vector),
    .O_WAKE             (wake)
  );

  always #5 I_CLOCK = ~I_CLOCK;

  task automatic step();
    @(posedge I_CLOCK);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    I_ADDR  = a;
    tb_data = d;
    tb_drv  = 1'b1;
    I_WE_L  = 1'b0;
    step();
    I_WE_L  = 1'b1;
    tb_drv  = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    I_ADDR = a;
    I_RE_L = 1'b0;
    #1;
    d      = IO_DATA;
    I_RE_L = 1'b1;
  endtask

  task automatic ack_cycle();
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (int_req !== 1'b0 || int_vector !== 16'h0000) begin
      $display("FAIL reset_outputs: req=%b vec=%h, expected 0/0000", int_req, int_vector);
    end else passed++;
    #10;
    I_RESET_L = 1'b1;
    step();
    bus_read(16'hFF0F, rd);
    total++;
    if (rd !== 8'hE0) $display("FAIL reset_if: got %h expected E0", rd);
    else passed++;
    bus_read(16'hFFFF, rd);
    total++;
    if (rd !== 8'h00) $display("FAIL reset_ie: got %h expected 00", rd);
    else passed++;
    // With the read strobe high the block must not contend with another driver.
    I_ADDR  = 16'hFF0F;
    tb_data = 8'h05;
    tb_drv  = 1'b1;
    #1;
    total++;
    if (IO_DATA !== 8'h05) $display("FAIL bus_idle_re_high: got %h expected 05", IO_DATA);
    else passed++;
    I_ADDR = 16'hFF00;
    I_RE_L = 1'b0;
    #1;
    total++;
    if (IO_DATA !== 8'h05) $display("FAIL bus_idle_other_addr: got %h expected 05", IO_DATA);
    else passed++;
    I_RE_L = 1'b1;
    tb_drv = 1'b0;
  endtask

  task automatic test_single_timer();
    bus_write(16'hFFFF, 8'h04);
    ime   = 1'b1;
    timer = 1'b1;
    step();
    timer = 1'b0;
    bus_read(16'hFF0F, rd);
    total++;
    if (rd !== 8'hE4) $display("FAIL timer_if_set: got %h expected E4", rd);
    else passed++;
    total++;
    if (int_req !== 1'b0) $display("FAIL timer_req_latency: got %b expected 0", int_req);
    else passed++;
    step();
    total++;
    if (int_req !== 1'b1 || int_vector !== 16'h0050) begin
      $display("FAIL timer_req: req=%b vec=%h expected 1/0050", int_req, int_vector);
    end else passed++;
    ack = 1'b1;
    step();
    total++;
    if (int_req !== 1'b0) $display("FAIL timer_req_drop_on_ack: got %b expected 0", int_req);
    else passed++;
    step();
    ack = 1'b0;
    step();
    step();
    bus_read(16'hFF0F, rd);
    total++;
    if (rd !== 8'hE0 || int_req !== 1'b0) begin
      $display("FAIL timer_after_ack: if=%h req=%b expected E0/0", rd, int_req);
    end else passed++;
  endtask

  task automatic test_priority();
    bus_write(16'hFFFF, 8'h1F);
    vblank = 1'b1;
    timer  = 1'b1;
    step();
    vblank = 1'b0;
    timer  = 1'b0;
    step();
    total++;
    if (int_req !== 1'b1 || int_vector !== 16'h0040) begin
      $display("FAIL prio_vblank: req=%b vec=%h expected 1/0040", int_req, int_vector);
    end else passed++;
    ack_cycle();
    step();
    total++;
    if (int_req !== 1'b1 || int_vector !== 16'h0050) begin
      $display("FAIL prio_timer_next: req=%b vec=%h expected 1/0050", int_req, int_vector);
    end else passed++;
    ack_cycle();
    bus_read(16'hFF0F, rd);
    total++;
    if (rd !== 8'hE0) $display("FAIL prio_if_clear: got %h expected E0", rd);
    else passed++;
  endtask

  task automatic test_preempt();
    serial = 1'b1;
    step();
    serial = 1'b0;
    step();
    total++;
    if (int_req !== 1'b1 || int_vector !== 16'h0058) begin
      $display("FAIL preempt_serial: req=%b vec=%h expected 1/0058", int_req, int_vector);
    end else passed++;
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    step();
    total++;
    if (int_req !== 1'b1 || int_vector !== 16'h0040) begin
      $display("FAIL preempt_vblank: req=%b vec=%h expected 1/0040", int_req, int_vector);
    end else passed++;
    ack_cycle();
    bus_read(16'hFF0F, rd);
    total++;
    if (rd !== 8'hE8) $display("FAIL preempt_ack_clears_vblank: got %h expected E8", rd);
    else passed++;
    step();
    total++;
    if (int_req !== 1'b1 || int_vector !== 16'h0058) begin
      $display("FAIL preempt_serial_again: req=%b vec=%h expected 1/0058", int_req, int_vector);
    end else passed++;
    ack_cycle();
  endtask

  task automatic test_ime_gating();
    ime = 1'b0;
    bus_write(16'hFFFF, 8'h10);
    joypad = 1'b1;
    step();
    joypad = 1'b0;
    step();
    bus_read(16'hFF0F, rd);
    total++;
    if (int_req !== 1'b0 || wake !== 1'b1 || rd !== 8'hF0) begin
      $display("FAIL ime_off: req=%b wake=%b if=%h expected 0/1/F0", int_req, wake, rd);
    end else passed++;
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    bus_read(16'hFF0F, rd);
    total++;
    if (rd !== 8'hF0) $display("FAIL idle_ack_ignored: got %h expected F0", rd);
    else passed++;
    ime = 1'b1;
    step();
    total++;
    if (int_req !== 1'b1 || int_vector !== 16'h0060) begin
      $display("FAIL ime_on_joypad: req=%b vec=%h expected 1/0060", int_req, int_vector);
    end else passed++;
    ack_cycle();
    total++;
    if (wake !== 1'b0) $display("FAIL wake_cleared: got %b expected 0", wake);
    else passed++;
  endtask

  task automatic test_write_vs_edge();
    ime = 1'b0;
    bus_write(16'hFFFF, 8'h04);
    I_ADDR  = 16'hFF0F;
    tb_data = 8'h00;
    tb_drv  = 1'b1;
    I_WE_L  = 1'b0;
    timer   = 1'b1;
    step();
    I_WE_L  = 1'b1;
    tb_drv  = 1'b0;
    timer   = 1'b0;
    bus_read(16'hFF0F, rd);
    total++;
    if (rd !== 8'hE4) $display("FAIL edge_beats_write: got %h expected E4", rd);
    else passed++;
    bus_write(16'hFF0F, 8'h00);
    timer = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus_write(16'hFF0F, 8'h00);
    for (int i = 0; i < 5; i++) step();
    bus_read(16'hFF0F, rd);
    total++;
    if (rd !== 8'hE0) $display("FAIL held_high_once: got %h expected E0", rd);
    else passed++;
    timer = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_handshake();
    ime   = 1'b1;
    timer = 1'b1;
    step();
    timer = 1'b0;
    step();
    total++;
    if (int_req !== 1'b1) $display("FAIL pre_reset_req: got %b expected 1", int_req);
    else passed++;
    #2;
    I_RESET_L = 1'b0;
    #1;
    total++;
    if (int_req !== 1'b0 || int_vector !== 16'h0000) begin
      $display("FAIL async_reset: req=%b vec=%h expected 0/0000", int_req, int_vector);
    end else passed++;
    bus_read(16'hFF0F, rd);
    total++;
    if (rd !== 8'hE0) $display("FAIL reset_mid_if: got %h expected E0", rd);
    else passed++;
    bus_read(16'hFFFF, rd);
    total++;
    if (rd !== 8'h00) $display("FAIL reset_mid_ie: got %h expected 00", rd);
    else passed++;
    step();
    I_RESET_L = 1'b1;
    step();
    bus_write(16'hFFFF, 8'hAA);
    bus_read(16'hFFFF, rd);
    total++;
    if (rd !== 8'hAA) $display("FAIL ie_full_byte: got %h expected AA", rd);
    else passed++;
    serial = 1'b1;
    step();
    serial = 1'b0;
    step();
    total++;
    if (int_req !== 1'b1 || int_vector !== 16'h0058 || wake !== 1'b1) begin
      $display("FAIL ie_aa_serial: req=%b vec=%h wake=%b expected 1/0058/1",
               int_req, int_vector, wake);
    end else passed++;
    ack_cycle();
    bus_read(16'hFF0F, rd);
    total++;
    if (rd !== 8'hE0 || int_req !== 1'b0) begin
      $display("FAIL ie_aa_done: if=%h req=%b expected E0/0", rd, int_req);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_single_timer();
    test_priority();
    test_preempt();
    test_ime_gating();
    test_write_vs_edge();
    test_reset_mid_handshake();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Memory-mapped Game Boy interrupt controller. Owns IF (0xFF0F) and IE (0xFFFF) and latches requests from the VBlank, LCDC, timer (timer_module O_TIMER_INTERRUPT), serial and joypad sources. It arbitrates the pending, enabled requests by fixed priority and runs a request/acknowledge handshake with the CPU that supplies the dispatch vector. It sits on the same I/O bus as the timer and other peripherals.

Parameters:
IF_ADDR, 16'hFF0F, address of the interrupt flag register
IE_ADDR, 16'hFFFF, address of the interrupt enable register
VECTOR_BASE, 16'h0040, vector of source 0 (VBlank)
VECTOR_STRIDE, 8, vector spacing between sources

Ports:
I_CLOCK  input  1  system clock, all state on the rising edge
I_RESET_L  input  1  asynchronous, active-low reset
I_ADDR  input  16  bus address
IO_DATA  inout  8  bus data; driven only during a matching read, otherwise Z
I_RE_L  input  1  active-low read strobe
I_WE_L  input  1  active-low write strobe
I_VBLANK_INTERRUPT  input  1  source 0, edge-detected
I_LCDC_INTERRUPT  input  1  source 1, edge-detected
I_TIMER_INTERRUPT  input  1  source 2, edge-detected
I_SERIAL_INTERRUPT  input  1  source 3, edge-detected
I_JOYPAD_INTERRUPT  input  1  source 4, edge-detected
I_IME  input  1  CPU master interrupt enable
I_INT_ACK  input  1  CPU acknowledge, level
O_INT_REQ  output  1  registered interrupt request to the CPU
O_INT_VECTOR  output  16  dispatch address, valid while O_INT_REQ=1
O_WAKE  output  1  combinational |(IF[4:0] & IE[4:0]), independent of IME; used for HALT/STOP exit

Behaviour:
- Reset (async, I_RESET_L=0):
  - IF[4:0]=0, IE=8'h00, edge registers=0, state=IDLE.
  - O_INT_REQ=0, O_INT_VECTOR=16'h0000.
  - Reset is effective mid-handshake; all state clears immediately.
  - Because edge registers clear to 0, a source held high at reset release sets its IF bit on the first clock.
- Edge detect: each source is registered every cycle. A 0->1 transition sets IF[n] on that clock edge. A held-high source sets the bit only once.
- Bus writes:
  - At posedge with I_WE_L=0 and I_ADDR==IF_ADDR: IF[4:0] <= IO_DATA[4:0].
  - With I_ADDR==IE_ADDR: IE <= IO_DATA (all 8 bits stored).
  - Other addresses are ignored.
- Bus reads: combinational while I_RE_L=0 and the address matches.
  - IF reads as {3'b111, IF[4:0]}; IE reads all 8 bits.
  - Otherwise IO_DATA=Z. The block never drives the bus with I_RE_L=1.
- IF update priority per bit, same cycle: source edge set > acknowledge clear > bus write. A set always survives.
- pending = IF[4:0] & IE[4:0]. Winner = lowest set bit index n. Vector = VECTOR_BASE + 8*n (0x40, 0x48, 0x50, 0x58, 0x60).
- FSM:
  - IDLE: O_INT_REQ=0. If I_IME & |pending, go to REQ (O_INT_REQ rises 1 clock after pending is visible).
  - REQ: O_INT_REQ=1. O_INT_VECTOR updates each clock to the current winner, so a higher-priority arrival preempts before the ack.
    - If I_IME=0 or pending==0: go to IDLE, O_INT_REQ=0, IF unchanged.
    - If I_INT_ACK=1: clear IF bit of the currently presented vector, go to ACK, O_INT_REQ=0.
  - ACK: hold O_INT_VECTOR. Wait for I_INT_ACK=0, then go to IDLE. New requests are not raised until IDLE is reached.
- I_INT_ACK asserted in IDLE is ignored.
- O_INT_VECTOR holds its last value outside REQ/ACK.

Test Plan:
- Reset, then read IF_ADDR -> IO_DATA=8'hE0; read IE_ADDR -> 8'h00. With I_RE_L=1 -> IO_DATA=Z.
- IE=8'h04, I_IME=1, single-cycle timer pulse -> IF reads 8'hE4; O_INT_REQ=1 one clock later with vector 16'h0050. Ack high for 2 clocks then low -> IF=8'hE0, O_INT_REQ=0, state back to IDLE.
- IE=8'h1F, VBlank and timer edges in the same cycle -> vector 16'h0040. After the ack completes, O_INT_REQ re-rises with 16'h0050.
- I_IME=0, IE=8'h10, joypad edge -> O_INT_REQ stays 0, O_WAKE=1, IF=8'hF0. Raising I_IME -> request with vector 16'h0060.
- Bus write IF=8'h00 in the same cycle as a timer edge -> IF=8'hE4. Timer held high for 10 clocks, IF cleared by write mid-way -> IF stays 8'hE0.
- I_RESET_L pulsed low while in REQ -> O_INT_REQ=0 asynchronously, IF=8'hE0, IE=8'h00. Write IE=8'hAA -> reads back 8'hAA, and pending uses only bits 4:0.
